// File: rtl/fuzzy_pwm_out.sv
// fuzzy_pwm_out: clamps and slew-limits coprocessor results into a 100-step PWM duty,
// with a watchdog that falls back to a safe duty when results stop arriving.
module fuzzy_pwm_out #(
    parameter int PRESC_W         = 8,
    parameter int SLEW_MAX        = 5,
    parameter int TIMEOUT_PERIODS = 16,
    parameter int SAFE_DUTY       = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               valid,
    input  logic [7:0]         G_in,
    output logic               pwm_out,
    output logic [7:0]         duty_cur,
    output logic [7:0]         target,
    output logic               period_start,
    output logic               clamp_evt,
    output logic               timeout
);
    localparam logic signed [8:0] SLEW = 9'(SLEW_MAX);
    localparam logic [7:0] TMO = 8'(TIMEOUT_PERIODS);
    localparam logic [7:0] SAFE = 8'(SAFE_DUTY);

    logic [PRESC_W-1:0] r_pcnt;
    logic [6:0]         r_phase;
    logic [7:0]         r_wcnt;
    logic               w_tick;
    logic               w_bnd;
    logic               w_over;
    logic [7:0]         w_g_clamp;
    logic signed [8:0]  w_d;
    logic [7:0]         w_slewed;

    assign w_tick    = en && (r_pcnt == presc);
    assign w_bnd     = w_tick && (r_phase == 7'd99);
    assign w_over    = G_in > 8'd100;
    assign w_g_clamp = w_over ? 8'd100 : G_in;
    assign w_d       = $signed({1'b0, target}) - $signed({1'b0, duty_cur});
    // Slew always sees the registered target, so a same-cycle capture takes effect next period
    assign w_slewed  = (w_d > SLEW)  ? duty_cur + 8'(SLEW_MAX) :
                       (w_d < -SLEW) ? duty_cur - 8'(SLEW_MAX) : target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_phase      <= '0;
            r_wcnt       <= '0;
            duty_cur     <= '0;
            target       <= SAFE;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            clamp_evt    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // pcnt above a freshly lowered presc clears without producing a tick
            r_pcnt       <= (!en || r_pcnt >= presc) ? '0 : r_pcnt + 1'b1;
            r_phase      <= !en ? '0 : w_tick ? (w_bnd ? '0 : r_phase + 1'b1) : r_phase;
            pwm_out      <= en && ({1'b0, r_phase} < duty_cur);
            period_start <= w_bnd;
            clamp_evt    <= valid && w_over;
            if (w_bnd)
                duty_cur <= w_slewed;
            if (valid) begin
                target  <= w_g_clamp;
                r_wcnt  <= '0;
                timeout <= 1'b0;
            end else if (w_bnd && r_wcnt != TMO) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (r_wcnt + 8'd1 == TMO) begin
                    timeout <= 1'b1;
                    target  <= SAFE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fuzzy_pwm_out.sv
// tb_fuzzy_pwm_out: capture vectors, directed PWM/slew/watchdog sequences and
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_fuzzy_pwm_out;
    localparam int SLEW = 5;
    localparam int TMO  = 16;
    localparam int SAFE = 0;

    logic       clk = 1'b0;
    logic       rst, en, valid;
    logic [7:0] presc, G_in;
    logic       pwm_out, period_start, clamp_evt, timeout;
    logic [7:0] duty_cur, target;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pcnt, m_phase, m_duty, m_target, m_wcnt, m_pwm, m_ps, m_ce, m_to;

    typedef struct {
        int g;
        int exp_target;
        int exp_clamp;
    } cap_vec_t;
    cap_vec_t vecs[8];

    always #5 clk = ~clk;

    fuzzy_pwm_out #(.PRESC_W(8), .SLEW_MAX(SLEW), .TIMEOUT_PERIODS(TMO), .SAFE_DUTY(SAFE)) dut (
        .clk(clk), .rst(rst), .en(en), .presc(presc), .valid(valid), .G_in(G_in),
        .pwm_out(pwm_out), .duty_cur(duty_cur), .target(target),
        .period_start(period_start), .clamp_evt(clamp_evt), .timeout(timeout)
    );

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: one clock edge of the spec's rules, in plain integer arithmetic
    task automatic model_step();
        int tick, bnd, step;
        if (rst) begin
            m_pcnt = 0; m_phase = 0; m_duty = 0; m_target = SAFE; m_wcnt = 0;
            m_pwm = 0; m_ps = 0; m_ce = 0; m_to = 0;
            return;
        end
        tick  = (en && m_pcnt == int'(presc)) ? 1 : 0;
        bnd   = (tick == 1 && m_phase == 99) ? 1 : 0;
        m_pwm = (en && m_phase < m_duty) ? 1 : 0;
        m_ps  = bnd;
        m_ce  = (valid && G_in > 100) ? 1 : 0;
        step  = m_target - m_duty;
        step  = step > SLEW ? SLEW : (step < -SLEW ? -SLEW : step);
        if (bnd == 1) m_duty = m_duty + step;
        m_pcnt  = !en ? 0 : (m_pcnt >= int'(presc) ? 0 : m_pcnt + 1);
        m_phase = !en ? 0 : (tick == 1 ? (m_phase + 1) % 100 : m_phase);
        if (valid) begin
            m_target = G_in > 100 ? 100 : int'(G_in);
            m_wcnt = 0;
            m_to = 0;
        end else if (bnd == 1 && m_wcnt < TMO) begin
            m_wcnt++;
            if (m_wcnt == TMO) begin
                m_to = 1;
                m_target = SAFE;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model pwm_out", pwm_out, m_pwm);
        check("model duty_cur", duty_cur, m_duty);
        check("model target", target, m_target);
        check("model period_start", period_start, m_ps);
        check("model clamp_evt", clamp_evt, m_ce);
        check("model timeout", timeout, m_to);
    endtask

    task automatic wait_ps(int limit, output int gap);
        gap = 0;
        do begin
            cyc();
            gap++;
        end while (!period_start && gap < limit);
        if (!period_start) check("period_start wait expired", 0, 1);
    endtask

    task automatic count_high(int n, output int hi, output int ps);
        hi = 0;
        ps = 0;
        repeat (n) begin
            cyc();
            hi += int'(pwm_out);
            ps += int'(period_start);
        end
    endtask

    task automatic pulse_valid(int g);
        valid = 1'b1;
        G_in  = 8'(g);
        cyc();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int gap, hi, ps, nb;
        vecs = '{'{0, 0, 0}, '{50, 50, 0}, '{100, 100, 0}, '{101, 100, 1},
                 '{200, 100, 1}, '{255, 100, 1}, '{99, 99, 0}, '{30, 30, 0}};
        rst = 1'b1; en = 1'b0; presc = 8'd0; valid = 1'b0; G_in = 8'd0;
        cyc();
        cyc();
        rst = 1'b0;
        check("reset duty_cur", duty_cur, 0);
        check("reset target", target, SAFE);
        check("reset timeout", timeout, 0);
        check("reset pwm_out", pwm_out, 0);
        check("reset period_start", period_start, 0);

        en = 1'b1;
        foreach (vecs[i]) begin
            pulse_valid(vecs[i].g);
            check("vec target", target, vecs[i].exp_target);
            check("vec clamp_evt", clamp_evt, vecs[i].exp_clamp);
            cyc();
            check("vec clamp_evt drop", clamp_evt, 0);
        end

        // Slew ramp to 50 and a 50% period
        do_reset();
        pulse_valid(50);
        check("t1 target", target, 50);
        nb = 0;
        for (int k = 1; k <= 10; k++) begin
            wait_ps(150, gap);
            nb++;
            check("t1 ramp duty", duty_cur, 5 * k);
            if (k > 1) check("t1 period spacing", gap, 100);
        end
        count_high(100, hi, ps);
        nb += ps;
        check("t1 high cycles", hi, 50);

        // Watchdog expiry and slew down to the safe duty
        while (!timeout && nb < 20) begin
            wait_ps(150, gap);
            nb++;
        end
        check("t3 boundaries to timeout", nb, TMO);
        check("t3 timeout", timeout, 1);
        check("t3 target safe", target, SAFE);
        check("t3 duty held", duty_cur, 50);
        for (int k = 1; k <= 10; k++) begin
            wait_ps(150, gap);
            check("t3 ramp down", duty_cur, 50 - 5 * k);
        end
        pulse_valid(30);
        check("t3 timeout cleared", timeout, 0);
        check("t3 new target", target, 30);

        // Clamped command ramps to a constant-high output
        pulse_valid(200);
        check("t2 clamp_evt", clamp_evt, 1);
        check("t2 target", target, 100);
        cyc();
        check("t2 clamp_evt drop", clamp_evt, 0);
        for (int k = 0; k < 25 && duty_cur != 8'd100; k++) begin
            wait_ps(150, gap);
            pulse_valid(200);
        end
        check("t2 duty full", duty_cur, 100);
        count_high(100, hi, ps);
        check("t2 high cycles", hi, 100);

        // Prescaled period
        do_reset();
        presc = 8'd3;
        pulse_valid(25);
        for (int k = 1; k <= 5; k++) begin
            wait_ps(500, gap);
            check("t4 ramp duty", duty_cur, 5 * k);
            if (k > 1) check("t4 period spacing", gap, 400);
        end
        count_high(400, hi, ps);
        check("t4 high cycles", hi, 100);

        // Capture on the boundary edge itself
        do_reset();
        presc = 8'd0;
        pulse_valid(20);
        for (int k = 1; k <= 4; k++) wait_ps(150, gap);
        check("t5 duty before", duty_cur, 20);
        repeat (99) cyc();
        pulse_valid(80);
        check("t5 boundary seen", period_start, 1);
        check("t5 duty unchanged", duty_cur, 20);
        check("t5 target", target, 80);
        check("t5 wcnt", dut.r_wcnt, 0);
        wait_ps(150, gap);
        check("t5 duty next", duty_cur, 25);

        // Disable mid-period, then reset
        repeat (30) cyc();
        en = 1'b0;
        repeat (10) begin
            cyc();
            check("t6 pwm off", pwm_out, 0);
            check("t6 phase zero", dut.r_phase, 0);
            check("t6 duty hold", duty_cur, 25);
        end
        do_reset();
        check("t6 duty reset", duty_cur, 0);
        check("t6 target reset", target, SAFE);
        check("t6 timeout reset", timeout, 0);
        check("t6 pwm reset", pwm_out, 0);
        en = 1'b1;

        // Randomized traffic; the middle window is kept quiet so the watchdog fires
        for (int i = 0; i < 6000; i++) begin
            if (i >= 2000 && i < 4000) begin
                rst = 1'b0; en = 1'b1; presc = 8'd0; valid = 1'b0;
            end else begin
                rst = ($urandom_range(0, 2999) == 0);
                if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
                else if (en && $urandom_range(0, 499) == 0) en = 1'b0;
                if ($urandom_range(0, 299) == 0) presc = 8'($urandom_range(0, 2));
                valid = ($urandom_range(0, 149) == 0);
                G_in  = 8'($urandom_range(0, 255));
            end
            cyc();
        end
        rst = 1'b0;
        valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
